monit_ring_fifo: RTL and testbench
==================================

# monit_ring_fifo

Parametrised single-clock FIFO for the monitoring datapath. It sits between sample producers (ADC/observer modules) and the readout or transfer logic. It adds these features to the basic data buffer:
- occupancy level output and programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags and a synchronous flush;
- a selectable overwrite ("ring") mode that keeps the newest samples when the consumer stalls.

## Interface
- DATA_WIDTH, 32, width of one stored word
- DEPTH, 32, number of entries; power of two, >= 4
- PTR_WIDTH, 5, pointer width; must equal log2(DEPTH)
- AF_LEVEL, DEPTH-4, almost_full asserted when level >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 4, almost_empty asserted when level <= AE_LEVEL; legal range 0..DEPTH-1
- OVERWRITE, 0, 0 = reject writes when full; 1 = a write when full discards the oldest entry
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush: empties the FIFO and clears the sticky flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data, sampled when a write is accepted
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  one-cycle strobe: rd_data was updated by an accepted read
- level  out  PTR_WIDTH+1  number of stored entries, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- overflow  out  1  sticky; set when a write was rejected or an entry was discarded
- underflow  out  1  sticky; set when rd_en was asserted while empty

## Operation
- Priority on each edge:
  1. rst;
  2. clr;
  3. normal read/write.
  During an rst or clr cycle, wr_en and rd_en are ignored.
- Read acceptance: rd_acc = rd_en && !empty. On rd_acc:
  - rd_data <= mem[rd_ptr];
  - rd_ptr increments;
  - rd_valid = 1 next cycle.
  Otherwise rd_data holds its value and rd_valid = 0.
- Write acceptance, OVERWRITE=0: wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Write acceptance, OVERWRITE=1: wr_acc = wr_en.
  - If full and !rd_acc, the oldest entry is discarded: rd_ptr increments and level is unchanged.
- On wr_acc: mem[wr_ptr] <= wr_data and wr_ptr increments.
- Level update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged on both, on neither, or on an overwrite discard.
- Pointers wrap modulo DEPTH by natural binary rollover.
- Empty FIFO with wr_en and rd_en together: the write is accepted and the read is refused. There is no bypass path; underflow is set.
- overflow is set when:
  - OVERWRITE=0 and wr_en && full && !rd_acc; or
  - OVERWRITE=1 and a discard occurs.
- overflow and underflow stay set until rst or clr.
- All flags decode directly from the level register, so they change in the same cycle as level.
- clr behaviour:
  - zeroes wr_ptr, rd_ptr, level, rd_valid, overflow and underflow;
  - rd_data holds.
- Memory contents are never reset. Stale data is unreachable after rst or clr.

## Timing
- Reset values:
  - rd_data = 0, rd_valid = 0;
  - level = 0, full = 0, empty = 1;
  - almost_full = 0, almost_empty = 1;
  - overflow = 0, underflow = 0.
- Write to flags: a write accepted at edge N is reflected in level and the flags after edge N. A read can accept it from edge N+1.
- Read latency: rd_en sampled high at edge N (not empty) gives valid rd_data and rd_valid = 1 after edge N. Hold time is one cycle.
- Throughput: one read and one write per cycle, sustained, at any level between 1 and DEPTH-1.
- rst or clr asserted mid-burst: effective at that edge, and the state equals the reset state on the following cycle. The exception is that clr leaves rd_data untouched.
- No combinational path from wr_en or rd_en to any output.

## Test plan
Bench configuration: DATA_WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless noted.
- Fill then drain:
  - Stimulus: write 0x0001..0x0008, then 8 reads.
  - Required: level reaches 8 and full=1; almost_full first rises at level 6; rd_data returns 0x0001..0x0008 in order, each with rd_valid; then empty=1 and almost_empty=1, with both flags clear.
- Full reject (OVERWRITE=0):
  - Stimulus: a 9th write of 0xAAAA while full.
  - Required: level stays 8; overflow=1; the next 8 reads return 0x0001..0x0008 with no 0xAAAA.
- Ring mode (OVERWRITE=1):
  - Stimulus: write 0x0001..0x000A.
  - Required: level=8; overflow=1; 8 reads return 0x0003..0x000A.
- Simultaneous access:
  - Full, rd_en and wr_en with 0x00FF: level stays 8, overflow stays 0, rd_data=0x0001.
  - Empty, both asserted: level becomes 1, rd_valid=0, underflow=1.
- Wrap-around: 20 cycles of continuous write+read at level 3. Required: data order preserved across pointer rollover; level constant at 3.
- Flush and reset:
  - Stimulus: clr asserted at level 5 with overflow set.
  - Required: next cycle level=0, empty=1, overflow=0, rd_data unchanged.
  - Then rst with level 4: all outputs at reset values, including rd_data=0.

Source files
------------

// File: rtl/monit_ring_fifo.sv
// Single-clock monitoring FIFO: level and threshold flags, sticky error flags, synchronous flush, optional ring overwrite.
// rd_data_o is registered one cycle after an accepted read; a write when full is rejected or, in ring mode, drops the oldest entry.
module monit_ring_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int PTR_WIDTH  = 5,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [PTR_WIDTH:0]    level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [PTR_WIDTH:0]   DEPTH_L = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   AF_L    = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_L    = (PTR_WIDTH+1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH:0]   LVL_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, rd_acc, wr_acc, discard;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign rd_acc  = rd_en_i && !empty;
  assign wr_acc  = OVERWRITE ? wr_en_i : (wr_en_i && (!full || rd_acc));
  // Ring mode only: a write into a full FIFO with no read pushes the oldest entry out.
  assign discard = OVERWRITE && wr_en_i && full && !rd_acc;

  always_comb begin
    level_d     = level_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc && !rd_acc && !discard) begin
      level_d = level_q + LVL_ONE;
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LVL_ONE;
    end
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc || discard) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (wr_en_i && full && !rd_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en_i && empty) begin
      underflow_d = 1'b1;
    end
  end

  // Storage is never reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clr_i && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign level_o        = level_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (level_q >= AF_L);
  assign almost_empty_o = (level_q <= AE_L);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_monit_ring_fifo.sv
// Drives a reject-mode and a ring-mode FIFO with identical inputs and checks both against a queue model.
module tb_monit_ring_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0;

  logic [15:0] o_rdd [2];
  logic [3:0]  o_lvl [2];
  logic        o_rv [2], o_full [2], o_emp [2], o_af [2], o_ae [2], o_ov [2], o_un [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per mode plus the registered outputs.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] m_rdd [2];
  bit          m_rv [2], m_ov [2], m_un [2];

  always #5 clk = ~clk;

  monit_ring_fifo #(.DATA_WIDTH(16), .DEPTH(8), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .OVERWRITE(1'b0)) u_rej (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(o_rdd[0]), .rd_valid_o(o_rv[0]), .level_o(o_lvl[0]), .full_o(o_full[0]), .empty_o(o_emp[0]),
    .almost_full_o(o_af[0]), .almost_empty_o(o_ae[0]), .overflow_o(o_ov[0]), .underflow_o(o_un[0]));

  monit_ring_fifo #(.DATA_WIDTH(16), .DEPTH(8), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .OVERWRITE(1'b1)) u_ring (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(o_rdd[1]), .rd_valid_o(o_rv[1]), .level_o(o_lvl[1]), .full_o(o_full[1]), .empty_o(o_emp[1]),
    .almost_full_o(o_af[1]), .almost_empty_o(o_ae[1]), .overflow_o(o_ov[1]), .underflow_o(o_un[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [15:0] q[$];
      bit          fl, racc;
      if (m == 0) q = q0; else q = q1;
      if (rst) begin
        q.delete();
        m_rdd[m] = '0; m_rv[m] = 1'b0; m_ov[m] = 1'b0; m_un[m] = 1'b0;
      end else if (clr) begin
        q.delete();
        m_rv[m] = 1'b0; m_ov[m] = 1'b0; m_un[m] = 1'b0;
      end else begin
        fl   = (q.size() == 8);
        racc = rd_en && (q.size() != 0);
        if (rd_en && q.size() == 0) m_un[m] = 1'b1;
        m_rv[m] = racc;
        if (racc) m_rdd[m] = q.pop_front();
        if (wr_en) begin
          if (fl && !racc) begin
            m_ov[m] = 1'b1;
            if (m == 1) begin
              void'(q.pop_front());
              q.push_back(wr_data);
            end
          end else begin
            q.push_back(wr_data);
          end
        end
      end
      if (m == 0) q0 = q; else q1 = q;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int sz;
      sz = (m == 0) ? q0.size() : q1.size();
      chk($sformatf("m%0d_rd_data", m), 32'(o_rdd[m]), 32'(m_rdd[m]));
      chk($sformatf("m%0d_rd_valid", m), 32'(o_rv[m]), 32'(m_rv[m]));
      chk($sformatf("m%0d_level", m), 32'(o_lvl[m]), 32'(sz));
      chk($sformatf("m%0d_full", m), 32'(o_full[m]), 32'(sz == 8));
      chk($sformatf("m%0d_empty", m), 32'(o_emp[m]), 32'(sz == 0));
      chk($sformatf("m%0d_almost_full", m), 32'(o_af[m]), 32'(sz >= 6));
      chk($sformatf("m%0d_almost_empty", m), 32'(o_ae[m]), 32'(sz <= 2));
      chk($sformatf("m%0d_overflow", m), 32'(o_ov[m]), 32'(m_ov[m]));
      chk($sformatf("m%0d_underflow", m), 32'(o_un[m]), 32'(m_un[m]));
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit w, input bit rd, input logic [15:0] d);
    rst = r; clr = c; wr_en = w; rd_en = rd; wr_data = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0);
    chk("reset_rd_data", 32'(o_rdd[0]), 32'h0);
    chk("reset_empty", 32'(o_emp[0]), 32'h1);
    chk("reset_almost_empty", 32'(o_ae[0]), 32'h1);
    chk("reset_level", 32'(o_lvl[0]), 32'h0);

    // Fill 1..8
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0, 16'(i));
      chk("fill_level", 32'(o_lvl[0]), 32'(i));
      chk("fill_almost_full", 32'(o_af[0]), 32'(i >= 6));
    end
    chk("fill_full", 32'(o_full[0]), 32'h1);

    // 9th write while full: rejected in u_rej, drops 0x0001 in u_ring
    cyc(0, 0, 1, 0, 16'hAAAA);
    chk("reject_level", 32'(o_lvl[0]), 32'h8);
    chk("reject_overflow", 32'(o_ov[0]), 32'h1);
    chk("ring_discard_overflow", 32'(o_ov[1]), 32'h1);

    // Drain: u_rej must return 1..8 with no 0xAAAA
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 1, 16'h0);
      chk("drain_rd_data", 32'(o_rdd[0]), 32'(i));
      chk("drain_rd_valid", 32'(o_rv[0]), 32'h1);
    end
    chk("drain_empty", 32'(o_emp[0]), 32'h1);
    chk("drain_almost_empty", 32'(o_ae[0]), 32'h1);
    chk("drain_full_clear", 32'(o_full[0]), 32'h0);
    chk("drain_af_clear", 32'(o_af[0]), 32'h0);
    chk("ring_last_word", 32'(o_rdd[1]), 32'hAAAA);

    // Ring mode: 1..10 keeps 3..10
    cyc(1, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 0, 16'(i));
    chk("ring_level", 32'(o_lvl[1]), 32'h8);
    chk("ring_overflow", 32'(o_ov[1]), 32'h1);
    for (int i = 3; i <= 10; i++) begin
      cyc(0, 0, 0, 1, 16'h0);
      chk("ring_rd_data", 32'(o_rdd[1]), 32'(i));
    end

    // Simultaneous read+write while full
    cyc(1, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 0, 16'(i));
    cyc(0, 0, 1, 1, 16'h00FF);
    chk("simfull_level", 32'(o_lvl[0]), 32'h8);
    chk("simfull_overflow", 32'(o_ov[0]), 32'h0);
    chk("simfull_rd_data", 32'(o_rdd[0]), 32'h1);
    chk("simfull_ring_overflow", 32'(o_ov[1]), 32'h0);

    // Simultaneous read+write while empty
    cyc(1, 0, 0, 0, 16'h0);
    cyc(0, 0, 1, 1, 16'h0042);
    chk("simempty_level", 32'(o_lvl[0]), 32'h1);
    chk("simempty_rd_valid", 32'(o_rv[0]), 32'h0);
    chk("simempty_underflow", 32'(o_un[0]), 32'h1);

    // Wrap-around at level 3
    cyc(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 16'(16'h100 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1, 16'(16'h103 + i));
      chk("wrap_rd_data", 32'(o_rdd[0]), 32'(16'h100 + i));
      chk("wrap_level", 32'(o_lvl[0]), 32'h3);
    end

    // Flush at level 5 with overflow set, then reset at level 4
    cyc(1, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 0, 16'(i));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 16'h0);
    chk("preclr_level", 32'(o_lvl[0]), 32'h5);
    cyc(0, 1, 1, 1, 16'h7777);
    chk("clr_level", 32'(o_lvl[0]), 32'h0);
    chk("clr_empty", 32'(o_emp[0]), 32'h1);
    chk("clr_overflow", 32'(o_ov[0]), 32'h0);
    chk("clr_rd_data_rej", 32'(o_rdd[0]), 32'h3);
    chk("clr_rd_data_ring", 32'(o_rdd[1]), 32'h4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 16'(16'h50 + i));
    cyc(1, 0, 1, 1, 16'h0);
    chk("rst_rd_data", 32'(o_rdd[0]), 32'h0);
    chk("rst_level", 32'(o_lvl[0]), 32'h0);
    chk("rst_almost_empty", 32'(o_ae[0]), 32'h1);

    // Randomised traffic with phases biased towards full and towards empty
    for (int i = 0; i < 800; i++) begin
      int  wp;
      bit  r, c, w, rd;
      wp = ((i / 100) % 2 == 1) ? 80 : 30;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < 55);
      cyc(r, c, w, rd, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
